// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage sitting directly in front of the instruction decoder.
// Holds the program counter and drives a synchronous-read instruction memory.
// Taken branches are redirected through an internal 64-entry branch-target
// table. Fetch stops on the halt opcode. RUN cycles are counted for
// benchmarking.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset_n      asynchronous active-low reset
//   start        one-cycle pulse, begins execution at PC 0 from IDLE or HALT
//   stall        hold current PC / instruction
//   branch       decoder branch indication for the current instruction
//   taken        flag-unit condition result for the current instruction
//   lut_we       branch-target table write enable (ignored while running)
//   lut_addr     table write index
//   lut_data     absolute target PC to store
//   imem_addr    instruction memory read address (next PC, combinational)
//   imem_data    instruction memory read data
//   instr        instruction presented to the decoder
//   instr_valid  instr is a real instruction located at pc
//   pc           address of instr
//   done         program halted
//   cycle_count  RUN cycles since start, saturating
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int             PCW     = 10,
   parameter int             IW      = 9,
   parameter logic [IW-1:0]  HALT_OP = 9'h1FF,
   parameter int             CNTW    = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            stall,
   input  logic            branch,
   input  logic            taken,
   input  logic            lut_we,
   input  logic [5:0]      lut_addr,
   input  logic [PCW-1:0]  lut_data,
   output logic [PCW-1:0]  imem_addr,
   input  logic [IW-1:0]   imem_data,
   output logic [IW-1:0]   instr,
   output logic            instr_valid,
   output logic [PCW-1:0]  pc,
   output logic            done,
   output logic [CNTW-1:0] cycle_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_next_s;
   logic [PCW-1:0]  pc_r;
   logic [PCW-1:0]  pc_next_s;
   logic [CNTW-1:0] count_r;
   logic            valid_r;
   logic            done_r;
   logic [PCW-1:0]  lut_r [64];
   logic [PCW-1:0]  target_s;
   logic            is_halt_s;

   // The memory output is the instruction for pc, so it passes straight through.
   assign instr     = imem_data;
   assign is_halt_s = (imem_data == HALT_OP);
   // Table reads are combinational on the current instruction's low six bits.
   assign target_s  = lut_r[imem_data[5:0]];

   // Next-state decode for the IDLE/RUN/HALT controller.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_next_s = ST_RUN;
            else       state_next_s = ST_IDLE;
         end
         ST_RUN: begin
            // A stalled halt keeps running so the halt is seen again once released.
            if (is_halt_s && !stall) state_next_s = ST_HALT;
            else                     state_next_s = ST_RUN;
         end
         ST_HALT: begin
            if (start) state_next_s = ST_RUN;
            else       state_next_s = ST_HALT;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Next-PC selection; a stall suppresses any redirect so the held branch re-evaluates.
   always_comb begin
      pc_next_s = pc_r;
      if (state_r == ST_RUN) begin
         if (stall)                pc_next_s = pc_r;
         else if (is_halt_s)       pc_next_s = pc_r;
         else if (branch && taken) pc_next_s = target_s;
         else                      pc_next_s = pc_r + PCW'(1);
      end else begin
         pc_next_s = pc_r;
      end
   end

   // The memory registers this address, so the fetch for pc_next lands with pc_next.
   assign imem_addr = (state_r == ST_RUN) ? pc_next_s : {PCW{1'b0}};

   // Controller state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= ST_IDLE;
      else          state_r <= state_next_s;
   end

   // Program counter: follows pc_next while running, restarts at 0 on start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_r <= {PCW{1'b0}};
      end else if (state_r == ST_RUN) begin
         pc_r <= pc_next_s;
      end else if (start) begin
         pc_r <= {PCW{1'b0}};
      end else begin
         pc_r <= pc_r;
      end
   end

   // Saturating RUN-cycle counter, cleared on start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= {CNTW{1'b0}};
      end else if (state_r == ST_RUN) begin
         if (count_r != {CNTW{1'b1}}) count_r <= count_r + CNTW'(1);
         else                         count_r <= count_r;
      end else if (start) begin
         count_r <= {CNTW{1'b0}};
      end else begin
         count_r <= count_r;
      end
   end

   // Registered status flags decoded from the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         valid_r <= (state_next_s == ST_RUN);
         done_r  <= (state_next_s == ST_HALT);
      end
   end

   // Branch-target table; writable only outside RUN so reads never collide with writes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 64; i++) lut_r[i] <= {PCW{1'b0}};
      end else if (lut_we && (state_r != ST_RUN)) begin
         lut_r[lut_addr] <= lut_data;
      end else begin
         lut_r <= lut_r;
      end
   end

   assign pc          = pc_r;
   assign cycle_count = count_r;
   assign instr_valid = valid_r;
   assign done        = done_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit with a synchronous-read ROM model. A table of
// per-cycle records drives the inputs and holds hand-computed expectations for
// imem_addr (before the edge) and pc / instr / instr_valid / done / cycle_count
// (after the edge). Hand-written sequences cover counter saturation and an
// asynchronous reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start, stall, branch, taken, lut_we;
   logic [5:0] lut_addr;
   logic [9:0] lut_data;
   logic [9:0] imem_addr;
   logic [8:0] imem_data;
   logic [8:0] instr;
   logic       instr_valid;
   logic [9:0] pc;
   logic       done;
   logic [15:0] cycle_count;

   logic [8:0] rom [1024];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       st, sl, br, tk, we;
      logic [5:0] la;
      logic [9:0] ld;
      logic [9:0] ea;
      logic [9:0] ep;
      logic [8:0] ei;
      logic       ev, ed;
      logic [15:0] ec;
   } vec_t;

   vec_t vecs[$];

   fetch_unit #(.PCW(10), .IW(9), .HALT_OP(9'h1FF), .CNTW(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
      .branch(branch), .taken(taken), .lut_we(lut_we), .lut_addr(lut_addr),
      .lut_data(lut_data), .imem_addr(imem_addr), .imem_data(imem_data),
      .instr(instr), .instr_valid(instr_valid), .pc(pc), .done(done),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory.
   always @(posedge clk) imem_data <= rom[imem_addr];

   function automatic vec_t mk(input logic st, input logic sl, input logic br,
                               input logic tk, input logic we, input logic [5:0] la,
                               input logic [9:0] ld, input logic [9:0] ea,
                               input logic [9:0] ep, input logic [8:0] ei,
                               input logic ev, input logic ed, input logic [15:0] ec);
      vec_t v;
      v.st = st; v.sl = sl; v.br = br; v.tk = tk; v.we = we; v.la = la; v.ld = ld;
      v.ea = ea; v.ep = ep; v.ei = ei; v.ev = ev; v.ed = ed; v.ec = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0; stall = 1'b0; branch = 1'b0; taken = 1'b0;
      lut_we = 1'b0; lut_addr = 6'd0; lut_data = 10'd0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      start = v.st; stall = v.sl; branch = v.br; taken = v.tk;
      lut_we = v.we; lut_addr = v.la; lut_data = v.ld;
      #1;
      chk($sformatf("v%0d imem_addr", idx), {22'd0, imem_addr}, {22'd0, v.ea});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d pc", idx), {22'd0, pc}, {22'd0, v.ep});
      chk($sformatf("v%0d instr", idx), {23'd0, instr}, {23'd0, v.ei});
      chk($sformatf("v%0d valid", idx), {31'd0, instr_valid}, {31'd0, v.ev});
      chk($sformatf("v%0d done", idx), {31'd0, done}, {31'd0, v.ed});
      chk($sformatf("v%0d count", idx), {16'd0, cycle_count}, {16'd0, v.ec});
   endtask

   task automatic lut_write(input logic [5:0] a, input logic [9:0] d);
      @(negedge clk);
      lut_we = 1'b1; lut_addr = a; lut_data = d;
      @(negedge clk);
      lut_we = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 9'(i & 255);
      rom[2]    = 9'h103;
      rom[5]    = 9'h103;
      rom[10'h020] = 9'h005;
      rom[10'h022] = 9'h1FF;
      imem_data = 9'd0;
      idle_inputs();
      reset_n = 1'b0;

      // Reset state
      #12;
      chk("rst pc", {22'd0, pc}, 32'd0);
      chk("rst valid", {31'd0, instr_valid}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst count", {16'd0, cycle_count}, 32'd0);
      chk("rst imem_addr", {22'd0, imem_addr}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      lut_write(6'd3, 10'h020);
      lut_write(6'd5, 10'h3FE);

      //               st    sl    br    tk    we    la    ld       ea       ep       ei      ev    ed    ec
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h000,10'h000,9'h000,1'b1,1'b0,16'd0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h001,10'h001,9'h001,1'b1,1'b0,16'd1));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h002,10'h002,9'h103,1'b1,1'b0,16'd2));
      vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,1'b0,6'd0,10'h000,10'h003,10'h003,9'h003,1'b1,1'b0,16'd3));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h004,10'h004,9'h004,1'b1,1'b0,16'd4));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h005,10'h005,9'h103,1'b1,1'b0,16'd5));
      vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b0,6'd0,10'h000,10'h005,10'h005,9'h103,1'b1,1'b0,16'd6));
      vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b0,6'd0,10'h000,10'h005,10'h005,9'h103,1'b1,1'b0,16'd7));
      vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b0,6'd0,10'h000,10'h005,10'h005,9'h103,1'b1,1'b0,16'd8));
      vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,1'b0,6'd0,10'h000,10'h020,10'h020,9'h005,1'b1,1'b0,16'd9));
      vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,1'b0,6'd0,10'h000,10'h3FE,10'h3FE,9'h0FE,1'b1,1'b0,16'd10));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h3FF,10'h3FF,9'h0FF,1'b1,1'b0,16'd11));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h000,10'h000,9'h000,1'b1,1'b0,16'd12));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,6'd3,10'h111,10'h001,10'h001,9'h001,1'b1,1'b0,16'd13));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h002,10'h002,9'h103,1'b1,1'b0,16'd14));
      vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,1'b0,6'd0,10'h000,10'h020,10'h020,9'h005,1'b1,1'b0,16'd15));
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h021,10'h021,9'h021,1'b1,1'b0,16'd16));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h022,10'h022,9'h1FF,1'b1,1'b0,16'd17));
      vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,6'd0,10'h000,10'h022,10'h022,9'h1FF,1'b1,1'b0,16'd18));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h022,10'h022,9'h1FF,1'b0,1'b1,16'd19));
      vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,1'b0,6'd0,10'h000,10'h000,10'h022,9'h000,1'b0,1'b1,16'd19));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,6'd3,10'h040,10'h000,10'h022,9'h000,1'b0,1'b1,16'd19));
      vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h000,10'h000,9'h000,1'b1,1'b0,16'd0));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h001,10'h001,9'h001,1'b1,1'b0,16'd1));
      vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h002,10'h002,9'h103,1'b1,1'b0,16'd2));
      vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,1'b0,6'd0,10'h000,10'h040,10'h040,9'h040,1'b1,1'b0,16'd3));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Counter saturation: stall at pc 0x040 starting from count 3.
      @(negedge clk);
      idle_inputs();
      stall = 1'b1;
      for (int i = 0; i < 65531; i++) @(posedge clk);
      #1;
      chk("sat count 65534", {16'd0, cycle_count}, 32'd65534);
      @(posedge clk);
      #1;
      chk("sat count 65535", {16'd0, cycle_count}, 32'd65535);
      for (int i = 0; i < 3; i++) @(posedge clk);
      #1;
      chk("sat count held", {16'd0, cycle_count}, 32'd65535);
      chk("sat pc held", {22'd0, pc}, 32'h040);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      stall = 1'b0;
      @(posedge clk);
      #1;
      chk("pre-rst pc", {22'd0, pc}, 32'h041);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid rst pc", {22'd0, pc}, 32'd0);
      chk("mid rst valid", {31'd0, instr_valid}, 32'd0);
      chk("mid rst done", {31'd0, done}, 32'd0);
      chk("mid rst count", {16'd0, cycle_count}, 32'd0);
      chk("mid rst imem_addr", {22'd0, imem_addr}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      // IDLE without start: nothing moves.
      apply(mk(1'b0,1'b0,1'b1,1'b1,1'b0,6'd0,10'h000,10'h000,10'h000,9'h000,1'b0,1'b0,16'd0), 100);
      // Restart; table entry 3 was cleared, so the taken branch goes to 0.
      apply(mk(1'b1,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h000,10'h000,9'h000,1'b1,1'b0,16'd0), 101);
      apply(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h001,10'h001,9'h001,1'b1,1'b0,16'd1), 102);
      apply(mk(1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,10'h000,10'h002,10'h002,9'h103,1'b1,1'b0,16'd2), 103);
      apply(mk(1'b0,1'b0,1'b1,1'b1,1'b0,6'd0,10'h000,10'h000,10'h000,9'h000,1'b1,1'b0,16'd3), 104);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
